// File: rtl/hazard_pkg.sv
// Instruction field layout, opcode constants and operand decode helpers shared
// by the hazard/forwarding logic.
package hazard_pkg;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 27;
   localparam int RD_HI    = 26;
   localparam int RD_LO    = 22;
   localparam int RS_HI    = 21;
   localparam int RS_LO    = 17;
   localparam int RT_HI    = 16;
   localparam int RT_LO    = 12;
   localparam int ALUOP_HI = 6;
   localparam int ALUOP_LO = 2;

   localparam logic [4:0] OP_ALU  = 5'd0;
   localparam logic [4:0] OP_BNE  = 5'd2;
   localparam logic [4:0] OP_JAL  = 5'd3;
   localparam logic [4:0] OP_JR   = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_BLT  = 5'd6;
   localparam logic [4:0] OP_SW   = 5'd7;
   localparam logic [4:0] OP_LW   = 5'd8;
   localparam logic [4:0] OP_SETX = 5'd21;
   localparam logic [4:0] OP_BEX  = 5'd22;

   localparam logic [4:0] ALUOP_MUL = 5'd6;
   localparam logic [4:0] ALUOP_DIV = 5'd7;

   localparam logic [4:0] REG_RA     = 5'd31;
   localparam logic [4:0] REG_STATUS = 5'd30;

   typedef enum logic [1:0] {
      SEL_RF = 2'b00,
      SEL_XM = 2'b01,
      SEL_MW = 2'b10
   } fwd_sel_e;

   function automatic logic is_writer(input logic [31:0] ir);
      logic [4:0] op;
      op = ir[OP_HI:OP_LO];
      return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_JAL) || (op == OP_SETX);
   endfunction

   // Non-writers report r0, which the match logic treats as "no destination".
   function automatic logic [4:0] dest_reg(input logic [31:0] ir);
      logic [4:0] r;
      r = 5'd0;
      case (ir[OP_HI:OP_LO])
         OP_ALU, OP_ADDI, OP_LW: r = ir[RD_HI:RD_LO];
         OP_JAL:                 r = REG_RA;
         OP_SETX:                r = REG_STATUS;
         default:                r = 5'd0;
      endcase
      return r;
   endfunction

   function automatic logic [4:0] src_a(input logic [31:0] ir);
      logic [4:0] r;
      r = 5'd0;
      case (ir[OP_HI:OP_LO])
         OP_ALU, OP_ADDI, OP_SW, OP_LW: r = ir[RS_HI:RS_LO];
         OP_BNE, OP_BLT, OP_JR:         r = ir[RD_HI:RD_LO];
         OP_BEX:                        r = REG_STATUS;
         default:                       r = 5'd0;
      endcase
      return r;
   endfunction

   function automatic logic [4:0] src_b(input logic [31:0] ir);
      logic [4:0] r;
      r = 5'd0;
      case (ir[OP_HI:OP_LO])
         OP_ALU:         r = ir[RT_HI:RT_LO];
         OP_SW:          r = ir[RD_HI:RD_LO];
         OP_BNE, OP_BLT: r = ir[RS_HI:RS_LO];
         default:        r = 5'd0;
      endcase
      return r;
   endfunction

   function automatic logic is_multdiv(input logic [31:0] ir);
      return (ir[OP_HI:OP_LO] == OP_ALU) &&
             ((ir[ALUOP_HI:ALUOP_LO] == ALUOP_MUL) || (ir[ALUOP_HI:ALUOP_LO] == ALUOP_DIV));
   endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// Picks the bypass source for one operand; XM is newer than MW so it wins.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int REG_W = 5
)
(
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] xm_dest,
   input  logic [REG_W-1:0] mw_dest,
   output logic [1:0]       sel
);

   logic src_live;

   assign src_live = (src != '0);

   always_comb begin
      sel = SEL_RF;
      if (src_live && (src == xm_dest)) begin
         sel = SEL_XM;
      end else if (src_live && (src == mw_dest)) begin
         sel = SEL_MW;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass selection, load-use bubble insertion, blocking multdiv
// sequencing and a saturating stall-cycle counter for the five-stage core.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int INSN_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [INSN_W-1:0] fd_ir,
   input  logic [INSN_W-1:0] dx_ir,
   input  logic [INSN_W-1:0] xm_ir,
   input  logic [INSN_W-1:0] mw_ir,
   input  logic              md_done,
   output logic [1:0]        a_sel,
   output logic [1:0]        b_sel,
   output logic              mem_sel,
   output logic              stall_fd,
   output logic              stall_dx,
   output logic              flush_dx,
   output logic              md_start,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   logic             state_q, state_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic [REG_W-1:0] xm_dest, mw_dest, xm_rd, dx_rd;
   logic [REG_W-1:0] dx_src [2];
   logic [1:0]       dx_sel [2];
   logic             load_use, md_start_c, md_stall, md_stall_g;

   assign xm_dest   = dest_reg(xm_ir);
   assign mw_dest   = dest_reg(mw_ir);
   assign dx_src[0] = src_a(dx_ir);
   assign dx_src[1] = src_b(dx_ir);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_match #(.REG_W(REG_W)) u_match (
            .src     (dx_src[gi]),
            .xm_dest (xm_dest),
            .mw_dest (mw_dest),
            .sel     (dx_sel[gi])
         );
      end
   endgenerate

   assign a_sel = dx_sel[0];
   assign b_sel = dx_sel[1];

   assign xm_rd   = xm_ir[RD_HI:RD_LO];
   assign mem_sel = (xm_ir[OP_HI:OP_LO] == OP_SW) && is_writer(mw_ir) &&
                    (mw_dest == xm_rd) && (xm_rd != '0);

   // A source of r0 can never equal a live load destination, so "no source" needs no flag.
   assign dx_rd    = dx_ir[RD_HI:RD_LO];
   assign load_use = (dx_ir[OP_HI:OP_LO] == OP_LW) && (dx_rd != '0) &&
                     ((src_a(fd_ir) == dx_rd) || (src_b(fd_ir) == dx_rd));

   always_comb begin
      state_d    = state_q;
      md_start_c = 1'b0;
      md_stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_multdiv(dx_ir)) begin
               md_start_c = 1'b1;
               md_stall   = 1'b1;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (md_done) begin
               state_d = ST_IDLE;
            end else begin
               md_stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset masks the state-driven outputs even if DX still decodes as MUL/DIV.
   assign md_stall_g = md_stall && reset_n;
   assign md_start   = md_start_c && reset_n;
   assign md_busy    = (state_q == ST_BUSY);
   assign stall_dx   = md_stall_g;
   assign stall_fd   = load_use || md_stall_g;
   assign flush_dx   = load_use && !md_stall_g;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if ((load_use || md_stall) && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed vectors feed a scoreboard queue; a negedge monitor pops and checks
// every output of the hazard unit against the hand-computed expectation.
module tb_hazard_forward_unit;

   localparam int CNT_W = 3;

   logic              clock;
   logic              reset_n;
   logic [31:0]       fd_ir, dx_ir, xm_ir, mw_ir;
   logic              md_done;
   logic [1:0]        a_sel, b_sel;
   logic              mem_sel, stall_fd, stall_dx, flush_dx, md_start, md_busy;
   logic [CNT_W-1:0]  stall_cycles;

   typedef struct packed {
      logic [1:0]  a_sel;
      logic [1:0]  b_sel;
      logic        mem_sel;
      logic        stall_fd;
      logic        stall_dx;
      logic        flush_dx;
      logic        md_start;
      logic        md_busy;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      string name;
      exp_t  e;
   } sb_t;

   sb_t sb_q[$];
   sb_t cur;
   exp_t act;
   int  tests_run = 0;
   int  tests_failed = 0;

   hazard_forward_unit #(.INSN_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .fd_ir        (fd_ir),
      .dx_ir        (dx_ir),
      .xm_ir        (xm_ir),
      .mw_ir        (mw_ir),
      .md_done      (md_done),
      .a_sel        (a_sel),
      .b_sel        (b_sel),
      .mem_sel      (mem_sel),
      .stall_fd     (stall_fd),
      .stall_dx     (stall_dx),
      .flush_dx     (flush_dx),
      .md_start     (md_start),
      .md_busy      (md_busy),
      .stall_cycles (stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] rtype(input logic [4:0] op, rd, rs, rt, aluop);
      return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
   endfunction

   function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
      return {op, rd, rs, 17'd0};
   endfunction

   function automatic exp_t mk(input logic [1:0] a, b, input logic mem, sfd, sdx, fl, st, bz,
                               input int cnt);
      exp_t r;
      r.a_sel = a;  r.b_sel = b;  r.mem_sel = mem;
      r.stall_fd = sfd;  r.stall_dx = sdx;  r.flush_dx = fl;
      r.md_start = st;  r.md_busy = bz;  r.cnt = 16'(cnt);
      return r;
   endfunction

   task automatic vec(input string name, input logic rst, input logic [31:0] fd, dx, xm, mw,
                      input logic done, input exp_t e);
      sb_t t;
      @(posedge clock);
      #1;
      reset_n = rst;
      fd_ir   = fd;
      dx_ir   = dx;
      xm_ir   = xm;
      mw_ir   = mw;
      md_done = done;
      t.name  = name;
      t.e     = e;
      sb_q.push_back(t);
   endtask

   always @(negedge clock) begin
      if (sb_q.size() != 0) begin
         cur = sb_q.pop_front();
         act = mk(a_sel, b_sel, mem_sel, stall_fd, stall_dx, flush_dx, md_start, md_busy,
                  int'(stall_cycles));
         tests_run++;
         if (act !== cur.e) begin
            tests_failed++;
            $display("[TB] FAIL %s: got a=%b b=%b mem=%b sfd=%b sdx=%b fl=%b st=%b bz=%b cnt=%0d, want a=%b b=%b mem=%b sfd=%b sdx=%b fl=%b st=%b bz=%b cnt=%0d",
                     cur.name, act.a_sel, act.b_sel, act.mem_sel, act.stall_fd, act.stall_dx,
                     act.flush_dx, act.md_start, act.md_busy, act.cnt,
                     cur.e.a_sel, cur.e.b_sel, cur.e.mem_sel, cur.e.stall_fd, cur.e.stall_dx,
                     cur.e.flush_dx, cur.e.md_start, cur.e.md_busy, cur.e.cnt);
         end else begin
            $display("[TB] %s ok", cur.name);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] nop, mul8;
      nop  = 32'd0;
      mul8 = rtype(5'd0, 5'd8, 5'd1, 5'd2, 5'd6);
      reset_n = 1'b0;
      fd_ir = nop;  dx_ir = nop;  xm_ir = nop;  mw_ir = nop;
      md_done = 1'b0;

      // forwarding selects
      vec("reset_state", 0, nop, nop, nop, nop, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("fwd_xm_a_mw_b", 1, nop, rtype(0, 3, 1, 2, 0), itype(5, 1, 9), rtype(0, 2, 5, 6, 0), 0,
          mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      vec("fwd_xm_r0", 1, nop, rtype(0, 3, 1, 2, 0), itype(5, 0, 9), rtype(0, 2, 5, 6, 0), 0,
          mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      vec("fwd_xm_priority", 1, nop, itype(7, 4, 5), rtype(0, 4, 1, 1, 0), itype(5, 4, 1), 0,
          mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
      vec("mem_sel_lw_sw", 1, nop, nop, itype(7, 4, 5), itype(8, 4, 0), 0,
          mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      vec("mem_sel_r0", 1, nop, nop, itype(7, 0, 5), itype(8, 0, 1), 0,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("jal_jr", 1, nop, itype(4, 31, 0), nop, itype(3, 0, 0), 0,
          mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("setx_bex", 1, nop, itype(22, 0, 0), nop, itype(21, 0, 0), 0,
          mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("bne_both", 1, nop, itype(2, 3, 2), rtype(0, 2, 1, 1, 0), itype(5, 3, 1), 0,
          mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0));

      // load-use
      vec("load_use_a", 1, rtype(0, 7, 6, 1, 0), itype(8, 6, 2), nop, nop, 0,
          mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
      vec("load_use_resolve", 1, nop, rtype(0, 7, 6, 1, 0), nop, itype(8, 6, 2), 0,
          mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 1));
      vec("load_use_b", 1, itype(7, 6, 3), itype(8, 6, 2), nop, nop, 0,
          mk(0, 0, 0, 1, 0, 1, 0, 0, 1));
      vec("load_r0_no_stall", 1, rtype(0, 7, 0, 1, 0), itype(8, 0, 2), nop, nop, 0,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 2));

      // multdiv sequencing
      vec("md_reset", 0, nop, nop, nop, nop, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("md_issue_done_ignored", 1, nop, mul8, nop, nop, 1, mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
      vec("md_busy1", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 1));
      vec("md_busy2", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 2));
      vec("md_busy_vs_loaduse", 1, rtype(0, 7, 6, 1, 0), itype(8, 6, 2), nop, nop, 0,
          mk(0, 0, 0, 1, 1, 0, 0, 1, 3));
      vec("md_busy4", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 4));
      vec("md_busy5", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 5));
      vec("md_done_release", 1, nop, mul8, nop, nop, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 6));
      vec("md_idle", 1, nop, nop, nop, nop, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
      vec("md_done_idle_ignored", 1, nop, nop, nop, nop, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 6));

      // saturation, then reset mid-BUSY
      vec("md2_issue", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 1, 0, 6));
      vec("cnt_reach_max", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 7));
      vec("cnt_saturate", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 7));
      vec("reset_mid_busy", 0, nop, mul8, nop, nop, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("late_done_ignored", 1, nop, nop, nop, nop, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vec("post_reset_issue", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
      vec("post_reset_busy", 1, nop, mul8, nop, nop, 0, mk(0, 0, 0, 1, 1, 0, 0, 1, 1));
      vec("post_reset_done", 1, nop, mul8, nop, nop, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 2));

      @(posedge clock);
      #7;
      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
